// File: rtl/rv_alu_reg_if.sv
// Operand/control bus into the registered RV32I ALU and the result bus back out.
// Signal names follow the execute-stage port list; clock and reset stay outside.
interface rv_alu_reg_if;
    logic        i_en;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic [4:0]  i_ctrl;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_valid;

    modport master (
        output i_en, i_src_a, i_src_b, i_ctrl,
        input  o_result, o_zero, o_valid
    );

    modport slave (
        input  i_en, i_src_a, i_src_b, i_ctrl,
        output o_result, o_zero, o_valid
    );
endinterface

// File: rtl/rv_alu_reg.sv
// Registered RV32I execute-stage ALU: one result per enabled edge, 1-cycle latency.
// Define ALU_ZBB_EN to add the Zbb ANDN/ORN/XNOR/MIN/MAX/MINU/MAXU codes (11xxx).
module rv_alu_reg (
    input  logic          i_clk,
    input  logic          i_reset_n,
    rv_alu_reg_if.slave   bus
);
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] result_d;
    logic        zero_d;
    logic [31:0] result_q;
    logic        zero_q;
    logic        valid_q;

    assign src_a = bus.i_src_a;
    assign src_b = bus.i_src_b;
    assign shamt = src_b[4:0];
    assign lt_s  = $signed(src_a) < $signed(src_b);
    assign lt_u  = src_a < src_b;

    // Branch codes put the condition in bit 0 so execute can use it as taken.
    always_comb begin
        result_d = '0;
        case (bus.i_ctrl)
            5'b00000: result_d = src_a + src_b;
            5'b00001: result_d = src_a - src_b;
            5'b00010: result_d = src_a & src_b;
            5'b00011: result_d = src_a | src_b;
            5'b00100: result_d = src_a ^ src_b;
            5'b00101: result_d = src_a << shamt;
            5'b00110: result_d = src_a >> shamt;
            5'b00111: result_d = $unsigned($signed(src_a) >>> shamt);
            5'b01000: result_d = {31'b0, lt_s};
            5'b01001: result_d = {31'b0, lt_u};
            5'b01010: result_d = src_b;
            5'b10000: result_d = {31'b0, src_a == src_b};
            5'b10001: result_d = {31'b0, src_a != src_b};
            5'b10100: result_d = {31'b0, lt_s};
            5'b10101: result_d = {31'b0, ~lt_s};
            5'b10110: result_d = {31'b0, lt_u};
            5'b10111: result_d = {31'b0, ~lt_u};
`ifdef ALU_ZBB_EN
            5'b11000: result_d = src_a & ~src_b;
            5'b11001: result_d = src_a | ~src_b;
            5'b11010: result_d = ~(src_a ^ src_b);
            5'b11100: result_d = lt_s ? src_a : src_b;
            5'b11101: result_d = lt_s ? src_b : src_a;
            5'b11110: result_d = lt_u ? src_a : src_b;
            5'b11111: result_d = lt_u ? src_b : src_a;
`endif
            default:  result_d = '0;
        endcase
    end

    assign zero_d = (result_d == 32'd0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else if (bus.i_en) begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= 1'b1;
        end else begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.o_result = result_q;
    assign bus.o_zero   = zero_q;
    assign bus.o_valid  = valid_q;
endmodule

// File: tb/tb_rv_alu_reg.sv
// Directed bench for rv_alu_reg: reference model checked every cycle plus literal pins.
// Honours ALU_ZBB_EN the same way as the design.
module tb_rv_alu_reg;
    logic clk;
    logic reset_n;
    rv_alu_reg_if bus ();

    rv_alu_reg dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic on integers, shifts as multiply/divide.
    function automatic logic [31:0] model_f(input logic [4:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa;
        int          sb;
        int unsigned s;
        logic [63:0] wide;
        logic [31:0] r;
        sa = a;
        sb = b;
        s  = b % 32;
        r  = 32'd0;
        case (c)
            5'd0:  begin wide = {32'd0, a} + {32'd0, b}; r = wide[31:0]; end
            5'd1:  begin wide = {32'd0, a} + {32'd0, ~b} + 64'd1; r = wide[31:0]; end
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  begin wide = {32'd0, a} * (64'd1 << s); r = wide[31:0]; end
            5'd6:  r = a / (32'd1 << s);
            5'd7:  r = (sa < 0) ? ~((~a) / (32'd1 << s)) : a / (32'd1 << s);
            5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd10: r = b;
            5'd16: r = (a == b) ? 32'd1 : 32'd0;
            5'd17: r = (a != b) ? 32'd1 : 32'd0;
            5'd20: r = (sa < sb) ? 32'd1 : 32'd0;
            5'd21: r = (sa >= sb) ? 32'd1 : 32'd0;
            5'd22: r = (a < b) ? 32'd1 : 32'd0;
            5'd23: r = (a >= b) ? 32'd1 : 32'd0;
`ifdef ALU_ZBB_EN
            5'd24: r = a & ~b;
            5'd25: r = a | ~b;
            5'd26: r = ~(a ^ b);
            5'd28: r = (sa <= sb) ? a : b;
            5'd29: r = (sa >= sb) ? a : b;
            5'd30: r = (a <= b) ? a : b;
            5'd31: r = (a >= b) ? a : b;
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_result <= 32'd0;
            exp_zero   <= 1'b1;
            exp_valid  <= 1'b0;
        end else if (bus.i_en) begin
            exp_result <= model_f(bus.i_ctrl, bus.i_src_a, bus.i_src_b);
            exp_zero   <= (model_f(bus.i_ctrl, bus.i_src_a, bus.i_src_b) == 32'd0);
            exp_valid  <= 1'b1;
        end else begin
            exp_valid  <= 1'b0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_result", bus.o_result, exp_result);
            cmp("model_zero", {31'd0, bus.o_zero}, {31'd0, exp_zero});
            cmp("model_valid", {31'd0, bus.o_valid}, {31'd0, exp_valid});
        end
    end

    task automatic drive(input logic en, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b);
        bus.i_en    = en;
        bus.i_ctrl  = c;
        bus.i_src_a = a;
        bus.i_src_b = b;
        @(posedge clk);
        #1;
        $display("op en=%0b ctrl=%05b a=%h b=%h -> result=%h zero=%0b valid=%0b",
                 en, c, a, b, bus.o_result, bus.o_zero, bus.o_valid);
    endtask

    task automatic lit(input string name, input logic [31:0] r, input logic z, input logic v);
        cmp({name, "_result"}, bus.o_result, r);
        cmp({name, "_zero"}, {31'd0, bus.o_zero}, {31'd0, z});
        cmp({name, "_valid"}, {31'd0, bus.o_valid}, {31'd0, v});
    endtask

    logic [31:0] sweep_a [4] = '{32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0005};
    logic [31:0] sweep_b [4] = '{32'h0000_001F, 32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFB};

    initial begin
        reset_n     = 1'b0;
        bus.i_en    = 1'b1;
        bus.i_ctrl  = 5'b00000;
        bus.i_src_a = 32'd5;
        bus.i_src_b = 32'd3;
        @(posedge clk);
        chk_en = 1'b1;
        drive(1'b1, 5'b00000, 32'd5, 32'd3);
        lit("reset", 32'd0, 1'b1, 1'b0);
        reset_n = 1'b1;
        drive(1'b1, 5'b00000, 32'd5, 32'd3);
        lit("add_5_3", 32'd8, 1'b0, 1'b1);

        drive(1'b1, 5'b00000, 32'hFFFF_FFFF, 32'd1);
        lit("add_wrap", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b00001, 32'd3, 32'd5);
        lit("sub", 32'hFFFF_FFFE, 1'b0, 1'b1);
        drive(1'b1, 5'b00101, 32'd1, 32'h21);
        lit("sll_b5", 32'd2, 1'b0, 1'b1);
        drive(1'b1, 5'b00110, 32'h8000_0000, 32'd31);
        lit("srl31", 32'd1, 1'b0, 1'b1);
        drive(1'b1, 5'b00111, 32'h8000_0000, 32'd31);
        lit("sra31", 32'hFFFF_FFFF, 1'b0, 1'b1);
        drive(1'b1, 5'b00111, 32'h8765_4321, 32'd0);
        lit("sra0", 32'h8765_4321, 1'b0, 1'b1);

        drive(1'b1, 5'b01000, 32'hFFFF_FFFF, 32'd1);
        lit("slt", 32'd1, 1'b0, 1'b1);
        drive(1'b1, 5'b01001, 32'hFFFF_FFFF, 32'd1);
        lit("sltu", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b01000, 32'h8000_0000, 32'd0);
        lit("slt_min", 32'd1, 1'b0, 1'b1);
        drive(1'b1, 5'b01001, 32'h8000_0000, 32'd0);
        lit("sltu_min", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b10100, 32'hFFFF_FFFF, 32'd1);
        lit("blt", 32'd1, 1'b0, 1'b1);
        drive(1'b1, 5'b10101, 32'hFFFF_FFFF, 32'd1);
        lit("bge", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b10110, 32'hFFFF_FFFF, 32'd1);
        lit("bltu", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b10111, 32'hFFFF_FFFF, 32'd1);
        lit("bgeu", 32'd1, 1'b0, 1'b1);
        drive(1'b1, 5'b10000, 32'd7, 32'd7);
        lit("beq", 32'd1, 1'b0, 1'b1);
        drive(1'b1, 5'b10001, 32'd7, 32'd7);
        lit("bne", 32'd0, 1'b1, 1'b1);

        drive(1'b1, 5'b00010, 32'h0000_F0F0, 32'h0000_FF00);
        lit("and", 32'h0000_F000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'b00011, 32'hA5A5_0000 + i, 32'h0F0F_0000 - i);
            lit("stall", 32'h0000_F000, 1'b0, 1'b0);
        end

        drive(1'b1, 5'b00011, 32'h0000_00F0, 32'h0000_000F);
        lit("b2b_or", 32'h0000_00FF, 1'b0, 1'b1);
        drive(1'b1, 5'b00100, 32'hFFFF_0000, 32'hFF00_FF00);
        lit("b2b_xor", 32'h00FF_FF00, 1'b0, 1'b1);
        drive(1'b1, 5'b01010, 32'h1111_1111, 32'hABCD_E000);
        lit("b2b_passb", 32'hABCD_E000, 1'b0, 1'b1);
        drive(1'b1, 5'b00000, 32'd100, 32'd23);
        lit("b2b_add", 32'd123, 1'b0, 1'b1);

        drive(1'b1, 5'b01011, 32'hFFFF_FFFF, 32'd1);
        lit("undef_01011", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b10010, 32'd7, 32'd7);
        lit("undef_10010", 32'd0, 1'b1, 1'b1);
`ifdef ALU_ZBB_EN
        drive(1'b1, 5'b11100, 32'hFFFF_FFFF, 32'd1);
        lit("zbb_min", 32'hFFFF_FFFF, 1'b0, 1'b1);
        drive(1'b1, 5'b11111, 32'hFFFF_FFFF, 32'd1);
        lit("zbb_maxu", 32'hFFFF_FFFF, 1'b0, 1'b1);
`else
        drive(1'b1, 5'b11100, 32'hFFFF_FFFF, 32'd1);
        lit("nozbb_min", 32'd0, 1'b1, 1'b1);
        drive(1'b1, 5'b11111, 32'hFFFF_FFFF, 32'd1);
        lit("nozbb_maxu", 32'd0, 1'b1, 1'b1);
`endif

        // Every code against a few operand pairs; the per-cycle model check covers these.
        for (int c = 0; c < 32; c++) begin
            for (int p = 0; p < 4; p++) begin
                drive(1'b1, 5'(c), sweep_a[p], sweep_b[p]);
            end
        end

        reset_n = 1'b0;
        drive(1'b1, 5'b00000, 32'd1, 32'd1);
        lit("reset_again", 32'd0, 1'b1, 1'b0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_alu_reg.md
Name: rv_alu_reg

Overview:
- Registered RV32I integer ALU for the execute stage.
- Combinationally computes arithmetic, logic, shift, set-less-than and branch-compare results from two 32-bit operands and a 5-bit control code.
- Registers the result and zero flag, giving 1-cycle latency.
- Branch compares return the condition in result bit 0, which the execute stage uses as branch-taken.

Parameters:
- None. Data width is fixed at 32.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge
- i_reset_n  input  1  synchronous, active-low reset
- i_en  input  1  capture enable; 0 = hold outputs (stall)
- i_src_a  input  32  operand A (rs1 value or PC)
- i_src_b  input  32  operand B (rs2 value or immediate)
- i_ctrl  input  5  operation code
- o_result  output  32  registered result
- o_zero  output  1  registered flag, 1 when o_result == 0
- o_valid  output  1  1 in the cycle after a cycle with i_en=1

Behaviour:
- Reset: when i_reset_n=0 at a rising edge, o_result=0, o_zero=1, o_valid=0. Reset has priority over i_en.
- Capture: when i_en=1 and not in reset, at each edge register o_result=f(a,b,ctrl), o_zero=(f==0) and o_valid=1.
- Hold: when i_en=0, o_result and o_zero hold their values and o_valid=0.
- Latency: exactly 1 cycle. There is no combinational path from inputs to outputs.
- Shifts use b[4:0] only; b[31:5] is ignored.
- Arithmetic wraps modulo 2^32. No overflow or carry flags.
- Signed ops use two's complement.
- i_ctrl encodings (unlisted codes yield result 0):
- 00000 ADD: a+b
- 00001 SUB: a-b
- 00010 AND
- 00011 OR
- 00100 XOR
- 00101 SLL: a<<b[4:0]
- 00110 SRL: logical right shift
- 00111 SRA: arithmetic right shift
- 01000 SLT: {31'b0, signed a<b}
- 01001 SLTU: {31'b0, unsigned a<b}
- 01010 PASSB: b (LUI)
- Branch compares use bit4=1 with the low 3 bits equal to the branch funct3. Each result is {31'b0, cond}.
- 10000 EQ: a==b
- 10001 NE: a!=b
- 10100 LT: signed a<b
- 10101 GE: signed a>=b
- 10110 LTU: unsigned a<b
- 10111 GEU: unsigned a>=b
- Codes 10010 and 10011 are undefined and yield result 0.
- Boundaries:
- SRA of 0x80000000 by 31 = 0xFFFFFFFF.
- SLT(0x80000000, 0) = 1, while SLTU of the same operands = 0.
- ADD 0xFFFFFFFF+1 = 0 with o_zero=1.
- Shift by 0 returns a unchanged.
- Operands and ctrl may change every cycle. Each edge with i_en=1 captures independently, giving back-to-back throughput of 1 op per cycle.

Optional Feature:
- Macro ALU_ZBB_EN.
- When defined, the following codes are added:
- 11000 ANDN: a & ~b
- 11001 ORN: a | ~b
- 11010 XNOR: ~(a^b)
- 11100 MIN: signed minimum
- 11101 MAX: signed maximum
- 11110 MINU: unsigned minimum
- 11111 MAXU: unsigned maximum
- When not defined, all 11xxx codes yield result 0 with o_zero=1. Base operations are identical in both builds.

Test Plan:
- Reset: hold i_reset_n=0 for 2 edges with i_en=1 and ADD 5+3 -> o_result=0, o_zero=1, o_valid=0. Release reset -> next edge o_result=8, o_zero=0, o_valid=1.
- Arithmetic:
- ADD 0xFFFFFFFF+1 -> 0, o_zero=1.
- SUB 3-5 -> 0xFFFFFFFE.
- Shifts:
- SLL 1 by b=0x21 -> 2 (only b[4:0] is used).
- SRL 0x80000000 by 31 -> 1.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF.
- Compares with a=0xFFFFFFFF, b=1:
- SLT -> 1 and SLTU -> 0.
- LT -> 1, GE -> 0, LTU -> 0, GEU -> 1.
- EQ 7,7 -> 1 and NE 7,7 -> 0.
- Stall and throughput:
- Compute AND 0xF0F0,0xFF00 = 0xF000, then set i_en=0 and change inputs for 3 cycles -> o_result stays 0xF000 and o_valid=0.
- Back-to-back ops issued on 4 consecutive edges -> each result appears exactly 1 cycle later.
- Undefined and Zbb codes:
- ctrl 01011 -> 0, o_zero=1.
- With ALU_ZBB_EN, MIN 0xFFFFFFFF,1 -> 0xFFFFFFFF and MAXU of the same operands -> 0xFFFFFFFF.
- Without ALU_ZBB_EN, ctrl 11100 -> 0.
